// File: rtl/rng_arbiter_pkg.sv
// Shared definitions for the rng blocks: arbiter FSM states, the default
// LFSR seed and a helper that keeps a seed away from the all-zero lock-up state.
package rng_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GATHER = 2'd1,
    ST_DONE   = 2'd2
  } arbState_t;

  localparam logic [3:0] RNG_DEFAULT_SEED = 4'b1001;

  // An all-zero LFSR never leaves zero, so a zero seed is replaced by 4'b0001.
  function automatic logic [3:0] safeSeed(input logic [3:0] seed);
    return (seed == 4'b0000) ? 4'b0001 : seed;
  endfunction

endpackage

// File: rtl/lfsr_4.sv
// Free-running 4-bit maximal-length LFSR (x^4 + x^3 + 1, period 15).
// next_bit is the feedback bit that will be shifted in at the coming edge.
module lfsr_4
  import rng_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] seed,
  output logic [3:0] state,
  output logic       next_bit
);

  logic [3:0] r_state;

  assign next_bit = r_state[3] ^ r_state[2];
  assign state    = r_state;

  // Shift left every clock, feedback into the LSB; reset reloads the seed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= safeSeed(seed);
    end else begin
      r_state <= {r_state[2:0], next_bit};
    end
  end

endmodule

// File: rtl/rng_arbiter.sv
// Round-robin arbiter sharing one 4-bit LFSR among NUM_REQ requesters.
// A granted requester receives OUT_W consecutive feedback bits (first bit in
// the MSB) together with a one-cycle gnt/rnd_valid pulse.
module rng_arbiter
  import rng_arbiter_pkg::*;
#(
  parameter int         NUM_REQ = 4,
  parameter int         OUT_W   = 8,
  parameter int         CNT_W   = 4,
  parameter logic [3:0] SEED    = RNG_DEFAULT_SEED
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [OUT_W-1:0]   rnd_data,
  output logic               rnd_valid,
  output logic               busy,
  output logic [3:0]         lfsr_state
);

  localparam int              OWN_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int              ACC_W      = (OUT_W > 1) ? (OUT_W - 1) : 1;
  localparam logic [3:0]      SEED_EFF   = safeSeed(SEED);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(OUT_W - 1);
  localparam logic [OWN_W-1:0] LAST_OWNER = OWN_W'(NUM_REQ - 1);

  arbState_t        r_state;
  arbState_t        w_nextState;
  logic [OWN_W-1:0] r_owner;
  logic [OWN_W-1:0] r_rr;
  logic [OWN_W-1:0] w_pick;
  logic [CNT_W-1:0] r_count;
  logic [ACC_W-1:0] r_acc;
  logic [OUT_W-1:0] w_accNext;
  logic [OUT_W-1:0] r_data;
  logic             w_nb;
  logic [3:0]       w_lfsrState;

  // First set request at or above the pointer, wrapping to index 0.
  function automatic logic [OWN_W-1:0] rrPick(input logic [NUM_REQ-1:0] reqs,
                                              input logic [OWN_W-1:0]   ptr);
    logic [OWN_W-1:0] pick;
    logic [OWN_W-1:0] idx;
    logic             found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = OWN_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && reqs[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  lfsr_4 u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .seed     (SEED_EFF),
    .state    (w_lfsrState),
    .next_bit (w_nb)
  );

  // Only the low OUT_W-1 bits of the accumulator need storing: the next word
  // is those bits with the freshly sampled feedback bit appended.
  generate
    if (OUT_W == 1) begin : g_singleBit
      assign w_accNext = w_nb;
    end else begin : g_multiBit
      assign w_accNext = {r_acc, w_nb};
    end
  endgenerate

  assign w_pick = rrPick(req, r_rr);

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: IDLE waits for any request, GATHER runs OUT_W edges, DONE lasts one cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:   if (req != '0) w_nextState = ST_GATHER;
      ST_GATHER: if (r_count == LAST_CNT) w_nextState = ST_DONE;
      ST_DONE:   w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  // Datapath: latch owner in IDLE, shift in feedback bits in GATHER, advance the pointer after DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner <= '0;
      r_rr    <= '0;
      r_count <= '0;
      r_acc   <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req != '0) begin
            r_owner <= w_pick;
            r_count <= '0;
          end
        end
        ST_GATHER: begin
          r_acc   <= w_accNext[ACC_W-1:0];
          r_count <= r_count + CNT_W'(1);
          if (r_count == LAST_CNT) begin
            r_data <= w_accNext;
          end
        end
        ST_DONE: begin
          r_rr <= (r_owner == LAST_OWNER) ? '0 : (r_owner + OWN_W'(1));
        end
        default: begin
        end
      endcase
    end
  end

  // One-hot grant decoded straight from the state so reset clears it asynchronously.
  always_comb begin
    gnt = '0;
    if (r_state == ST_DONE) begin
      gnt[r_owner] = 1'b1;
    end
  end

  assign rnd_data   = r_data;
  assign rnd_valid  = (r_state == ST_DONE);
  assign busy       = (r_state != ST_IDLE);
  assign lfsr_state = w_lfsrState;

endmodule

// File: tb/tb_rng_arbiter.sv
// Testbench for rng_arbiter: directed scenarios plus randomized requests,
// checked against a transaction-level model of the arbiter and the LFSR.
module tb_rng_arbiter;

  localparam int         NUM_REQ = 4;
  localparam int         OUT_W   = 8;
  localparam int         CNT_W   = 4;
  localparam logic [3:0] SEED    = 4'b1001;
  localparam int         PERIOD  = 10;

  logic               clk;
  logic               rst;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [OUT_W-1:0]   rnd_data;
  logic               rnd_valid;
  logic               busy;
  logic [3:0]         lfsr_state;

  int          total = 0;
  int          bad = 0;
  int          rrModel = 0;
  longint      lastGrantTime = 0;
  logic [3:0]  modelLfsr;
  bit          bitHist[$];
  logic [OUT_W-1:0] lastData;

  rng_arbiter #(
    .NUM_REQ (NUM_REQ),
    .OUT_W   (OUT_W),
    .CNT_W   (CNT_W),
    .SEED    (SEED)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .gnt        (gnt),
    .rnd_data   (rnd_data),
    .rnd_valid  (rnd_valid),
    .busy       (busy),
    .lfsr_state (lfsr_state)
  );

  initial clk = 1'b0;
  always #(PERIOD / 2) clk = ~clk;

  // Reference LFSR: new = (old*2 mod 16) + (bit3 xor bit2); history of every sampled feedback bit.
  always @(posedge clk or negedge rst) begin
    int fb;
    if (!rst) begin
      modelLfsr <= SEED;
      bitHist.delete();
    end else begin
      fb = ((int'(modelLfsr) / 8) + (int'(modelLfsr) / 4)) % 2;
      bitHist.push_back(fb[0]);
      if (bitHist.size() > 64) void'(bitHist.pop_front());
      modelLfsr <= 4'(((int'(modelLfsr) * 2) % 16) + fb);
    end
  end

  // The delivered word is the last OUT_W feedback bits, oldest first.
  function automatic logic [OUT_W-1:0] histWord();
    int w;
    w = 0;
    if (bitHist.size() < OUT_W) return '0;
    for (int i = bitHist.size() - OUT_W; i < bitHist.size(); i++) begin
      w = w * 2 + int'(bitHist[i]);
    end
    return OUT_W'(w);
  endfunction

  // Round-robin rule: first asserted request starting at the pointer, wrapping.
  function automatic int pickModel(input logic [NUM_REQ-1:0] r, input int ptr);
    int idx;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (ptr + k) % NUM_REQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive a request pattern while idle, wait for the grant and check the whole transaction.
  task automatic applyStimulus(input logic [NUM_REQ-1:0] reqVal, input bit pulse,
                               input bit checkSpacing, input string tag);
    int expOwner;
    int waited;
    bit sawGrant;
    bit busyOk;
    logic [OUT_W-1:0] expWord;
    req      = reqVal;
    expOwner = pickModel(reqVal, rrModel);
    waited   = 0;
    sawGrant = 1'b0;
    busyOk   = 1'b1;
    while (!sawGrant && waited < 40) begin
      @(negedge clk);
      waited++;
      if (pulse && waited == 1) req = '0;
      if (gnt != '0) sawGrant = 1'b1;
      else if (busy !== 1'b1) busyOk = 1'b0;
    end
    checkOutput({tag, "_granted"}, 32'(sawGrant), 32'd1);
    if (sawGrant) begin
      expWord = histWord();
      checkOutput({tag, "_latency"}, 32'(waited), 32'(OUT_W + 1));
      checkOutput({tag, "_busyGather"}, {31'd0, busyOk & busy}, 32'd1);
      checkOutput({tag, "_gnt"}, 32'(gnt), 32'(1 << expOwner));
      checkOutput({tag, "_valid"}, 32'(rnd_valid), 32'd1);
      checkOutput({tag, "_data"}, 32'(rnd_data), 32'(expWord));
      checkOutput({tag, "_lfsr"}, 32'(lfsr_state), 32'(modelLfsr));
      if (checkSpacing) begin
        checkOutput({tag, "_spacing"}, 32'($time - lastGrantTime), 32'((OUT_W + 2) * PERIOD));
      end
      lastGrantTime = $time;
      lastData      = rnd_data;
      rrModel       = (expOwner + 1) % NUM_REQ;
      @(negedge clk);
      checkOutput({tag, "_gntAfter"}, 32'(gnt), 32'd0);
      checkOutput({tag, "_validAfter"}, 32'(rnd_valid), 32'd0);
      checkOutput({tag, "_busyAfter"}, 32'(busy), 32'd0);
      checkOutput({tag, "_dataHeld"}, 32'(rnd_data), 32'(expWord));
    end
  endtask

  initial begin
    int gap;
    bit quietOk;
    bit nonZeroOk;
    bit modelOk;
    bit periodOk;
    logic [3:0] states[100];

    rst = 1'b1;
    req = 4'b0001;
    #1 rst = 1'b0;
    #1;
    $display("[TB] reset state");
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_valid", 32'(rnd_valid), 32'd0);
    checkOutput("rst_data", 32'(rnd_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_lfsr", 32'(lfsr_state), 32'(SEED));
    #1 rst = 1'b1;

    $display("[TB] first word after reset");
    applyStimulus(4'b0001, 1'b0, 1'b0, "first");
    checkOutput("first_word", 32'(lastData), 32'h5E);

    $display("[TB] round-robin fairness with all requests held");
    for (int n = 0; n < 5; n++) begin
      applyStimulus(4'b1111, 1'b0, 1'b1, "fair");
    end

    $display("[TB] wrap priority");
    req = '0;
    @(negedge clk);
    applyStimulus(4'b1000, 1'b0, 1'b0, "wrap3");
    applyStimulus(4'b1001, 1'b0, 1'b0, "wrapA");
    applyStimulus(4'b1001, 1'b0, 1'b0, "wrapB");

    $display("[TB] request dropped mid-gather");
    req = '0;
    @(negedge clk);
    applyStimulus(4'b0100, 1'b1, 1'b0, "drop");

    $display("[TB] reset in the middle of a gather");
    req = 4'b0001;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    rrModel = 0;
    #1;
    checkOutput("midrst_gnt", 32'(gnt), 32'd0);
    checkOutput("midrst_valid", 32'(rnd_valid), 32'd0);
    checkOutput("midrst_data", 32'(rnd_data), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_lfsr", 32'(lfsr_state), 32'(SEED));
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(4'b0001, 1'b0, 1'b0, "restart");
    checkOutput("restart_word", 32'(lastData), 32'h5E);

    $display("[TB] randomized requests");
    for (int n = 0; n < 20; n++) begin
      req = '0;
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      applyStimulus(NUM_REQ'($urandom_range(1, 15)), bit'($urandom_range(0, 1)), 1'b0, "rand");
    end

    $display("[TB] idle stability");
    req       = '0;
    quietOk   = 1'b1;
    nonZeroOk = 1'b1;
    modelOk   = 1'b1;
    periodOk  = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      states[c] = lfsr_state;
      if (gnt !== '0 || rnd_valid !== 1'b0 || busy !== 1'b0) quietOk = 1'b0;
      if (lfsr_state == 4'b0000) nonZeroOk = 1'b0;
      if (lfsr_state !== modelLfsr) modelOk = 1'b0;
    end
    for (int k = 0; k < 85; k++) begin
      if (states[k + 15] !== states[k]) periodOk = 1'b0;
      for (int d = 1; d < 15; d++) begin
        if (states[k + d] === states[k]) periodOk = 1'b0;
      end
    end
    checkOutput("idle_quiet", 32'(quietOk), 32'd1);
    checkOutput("idle_lfsrNonZero", 32'(nonZeroOk), 32'd1);
    checkOutput("idle_lfsrModel", 32'(modelOk), 32'd1);
    checkOutput("idle_lfsrPeriod15", 32'(periodOk), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
